// File: rtl/instr_decode.sv
// RV32IM instruction decoder with a 2-entry output/skid buffer and illegal-word counter.
// Define RV32M_DECODE_EN to decode the M extension; otherwise M-type words decode as illegal.
module instr_decode (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_IR_DV,
    input  logic [31:0] i_IR,
    output logic        o_IR_ready,
    output logic        o_DV,
    input  logic        i_ready,
    output logic [31:0] o_instruction,
    output logic [31:0] o_IR,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_illegal,
    output logic [15:0] o_illegal_cnt
);

    localparam logic [5:0] CODE_ILLEGAL = 6'd63;

    function automatic logic [5:0] decode(input logic [31:0] ir);
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] code;
        opcode = ir[6:0];
        f3     = ir[14:12];
        f7     = ir[31:25];
        code   = CODE_ILLEGAL;
        case (opcode)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'd0: code = 6'd0;
                        3'd1: code = 6'd2;
                        3'd2: code = 6'd3;
                        3'd3: code = 6'd4;
                        3'd4: code = 6'd5;
                        3'd5: code = 6'd6;
                        3'd6: code = 6'd8;
                        default: code = 6'd9;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'd0)      code = 6'd1;
                    else if (f3 == 3'd5) code = 6'd7;
                end
`ifdef RV32M_DECODE_EN
                else if (f7 == 7'b0000001) begin
                    code = 6'd10 + {3'd0, f3};
                end
`endif
            end
            7'b0010011: begin
                case (f3)
                    3'd0: code = 6'd18;
                    3'd2: code = 6'd19;
                    3'd3: code = 6'd20;
                    3'd4: code = 6'd21;
                    3'd6: code = 6'd22;
                    3'd7: code = 6'd23;
                    3'd1: if (f7 == 7'b0000000) code = 6'd24;
                    default: begin
                        if (f7 == 7'b0000000)      code = 6'd25;
                        else if (f7 == 7'b0100000) code = 6'd26;
                    end
                endcase
            end
            7'b0000011: begin
                case (f3)
                    3'd0: code = 6'd27;
                    3'd1: code = 6'd28;
                    3'd2: code = 6'd29;
                    3'd4: code = 6'd30;
                    3'd5: code = 6'd31;
                    default: code = CODE_ILLEGAL;
                endcase
            end
            7'b0100011: begin
                case (f3)
                    3'd0: code = 6'd32;
                    3'd1: code = 6'd33;
                    3'd2: code = 6'd34;
                    default: code = CODE_ILLEGAL;
                endcase
            end
            7'b1100011: begin
                case (f3)
                    3'd0: code = 6'd35;
                    3'd1: code = 6'd36;
                    3'd4: code = 6'd37;
                    3'd5: code = 6'd38;
                    3'd6: code = 6'd39;
                    3'd7: code = 6'd40;
                    default: code = CODE_ILLEGAL;
                endcase
            end
            7'b1101111: code = 6'd41;
            7'b1100111: if (f3 == 3'd0) code = 6'd42;
            7'b0110111: code = 6'd43;
            7'b0010111: code = 6'd44;
            default:    code = CODE_ILLEGAL;
        endcase
        return code;
    endfunction

    logic        out_vld_q, out_vld_d;
    logic [5:0]  out_code_q, out_code_d;
    logic [31:0] out_ir_q, out_ir_d;
    logic        skid_vld_q, skid_vld_d;
    logic [5:0]  skid_code_q, skid_code_d;
    logic [31:0] skid_ir_q, skid_ir_d;
    logic [15:0] cnt_q, cnt_d;

    logic [5:0]  new_code;
    logic        accept;
    logic        pop;

    assign new_code = decode(i_IR);
    // o_IR_ready is simply the registered skid-empty flag, so accept never depends on i_ready.
    assign accept   = i_IR_DV & ~skid_vld_q & ~i_flush;
    assign pop      = out_vld_q & i_ready;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_code_d  = out_code_q;
        out_ir_d    = out_ir_q;
        skid_vld_d  = skid_vld_q;
        skid_code_d = skid_code_q;
        skid_ir_d   = skid_ir_q;
        cnt_d       = cnt_q;

        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_vld_q && !pop) begin
            if (accept) begin
                skid_vld_d  = 1'b1;
                skid_code_d = new_code;
                skid_ir_d   = i_IR;
            end
        end else if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_code_d = skid_code_q;
            out_ir_d   = skid_ir_q;
            skid_vld_d = 1'b0;
        end else begin
            out_vld_d = accept;
            if (accept) begin
                out_code_d = new_code;
                out_ir_d   = i_IR;
            end
        end

        if (accept && (new_code == CODE_ILLEGAL) && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld_q   <= 1'b0;
            out_code_q  <= CODE_ILLEGAL;
            out_ir_q    <= 32'd0;
            skid_vld_q  <= 1'b0;
            skid_code_q <= CODE_ILLEGAL;
            skid_ir_q   <= 32'd0;
            cnt_q       <= 16'd0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_code_q  <= out_code_d;
            out_ir_q    <= out_ir_d;
            skid_vld_q  <= skid_vld_d;
            skid_code_q <= skid_code_d;
            skid_ir_q   <= skid_ir_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_IR_ready    = ~skid_vld_q;
    assign o_DV          = out_vld_q;
    assign o_instruction = {26'd0, out_code_q};
    assign o_IR          = out_ir_q;
    assign o_rs1         = out_ir_q[19:15];
    assign o_rs2         = out_ir_q[24:20];
    assign o_rd          = out_ir_q[11:7];
    assign o_illegal     = out_vld_q & (out_code_q == CODE_ILLEGAL);
    assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed self-checking bench for instr_decode; M-type expectations follow RV32M_DECODE_EN.
module tb_instr_decode;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ir_dv;
    logic [31:0] ir;
    logic        ir_ready;
    logic        dv;
    logic        rdy;
    logic [31:0] instr;
    logic [31:0] ir_out;
    logic [4:0]  rs1, rs2, rd;
    logic        illegal;
    logic [15:0] ill_cnt;

    int checks = 0;
    int errors = 0;

`ifdef RV32M_DECODE_EN
    localparam bit M_ON = 1'b1;
`else
    localparam bit M_ON = 1'b0;
`endif

    instr_decode dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_IR_DV      (ir_dv),
        .i_IR         (ir),
        .o_IR_ready   (ir_ready),
        .o_DV         (dv),
        .i_ready      (rdy),
        .o_instruction(instr),
        .o_IR         (ir_out),
        .o_rs1        (rs1),
        .o_rs2        (rs2),
        .o_rd         (rd),
        .o_illegal    (illegal),
        .o_illegal_cnt(ill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          code;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mcode(input int c);
        return M_ON ? c : 63;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dv"},    {31'd0, dv}, 32'd0);
        chk({tag, "_rdy"},   {31'd0, ir_ready}, 32'd1);
        chk({tag, "_instr"}, instr, 32'd63);
        chk({tag, "_ir"},    ir_out, 32'd0);
        chk({tag, "_rs"},    {17'd0, rs1, rs2, rd}, 32'd0);
        chk({tag, "_ill"},   {31'd0, illegal}, 32'd0);
        chk({tag, "_cnt"},   {16'd0, ill_cnt}, 32'd0);
    endtask

    logic [31:0] exp_code;
    int          exp_cnt;
    logic [31:0] div_word;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ir_dv = 1'b0;
        ir    = 32'd0;
        rdy   = 1'b1;
        exp_cnt = 0;
        div_word = 32'h02B54533;

        vecs.push_back('{32'h00B50533, 0});
        vecs.push_back('{32'h40B50533, 1});
        vecs.push_back('{32'h40B55533, 7});
        vecs.push_back('{32'h00B56533, 8});
        vecs.push_back('{32'h40B51533, 63});
        vecs.push_back('{32'h02B50533, mcode(10)});
        vecs.push_back('{32'h02B57533, mcode(17)});
        vecs.push_back('{32'h00150513, 18});
        vecs.push_back('{32'h40055513, 26});
        vecs.push_back('{32'h40051513, 63});
        vecs.push_back('{32'h00155513, 25});
        vecs.push_back('{32'h00052503, 29});
        vecs.push_back('{32'h00054503, 30});
        vecs.push_back('{32'h00053503, 63});
        vecs.push_back('{32'h00A52023, 34});
        vecs.push_back('{32'h00A53023, 63});
        vecs.push_back('{32'h00000063, 35});
        vecs.push_back('{32'h00007063, 40});
        vecs.push_back('{32'h00002063, 63});
        vecs.push_back('{32'h0000006F, 41});
        vecs.push_back('{32'h00000067, 42});
        vecs.push_back('{32'h00001067, 63});
        vecs.push_back('{32'h12345537, 43});
        vecs.push_back('{32'h00000517, 44});
        vecs.push_back('{32'h00000000, 63});

        #12;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // add a0,a0,a1 with downstream ready
        ir_dv = 1'b1;
        ir    = 32'h00B50533;
        tick();
        ir_dv = 1'b0;
        chk("add_dv",    {31'd0, dv}, 32'd1);
        chk("add_instr", instr, 32'd0);
        chk("add_rd",    {27'd0, rd},  32'd10);
        chk("add_rs1",   {27'd0, rs1}, 32'd10);
        chk("add_rs2",   {27'd0, rs2}, 32'd11);
        chk("add_ir",    ir_out, 32'h00B50533);
        tick();
        chk("add_retire", {31'd0, dv}, 32'd0);

        foreach (vecs[i]) begin
            ir_dv = 1'b1;
            ir    = vecs[i].word;
            tick();
            ir_dv = 1'b0;
            if (vecs[i].code == 63) exp_cnt++;
            chk($sformatf("vec%0d_instr", i), instr, 32'(vecs[i].code));
            chk($sformatf("vec%0d_ill", i), {31'd0, illegal}, (vecs[i].code == 63) ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d_cnt", i), {16'd0, ill_cnt}, 32'(exp_cnt));
            tick();
        end

        // div held for 26 stall cycles
        rdy   = 1'b0;
        ir_dv = 1'b1;
        ir    = div_word;
        tick();
        ir_dv = 1'b0;
        ir    = 32'h0;
        exp_code = 32'(mcode(14));
        if (!M_ON) exp_cnt++;
        for (int c = 0; c < 26; c++) begin
            chk($sformatf("div_hold%0d_dv", c), {31'd0, dv}, 32'd1);
            chk($sformatf("div_hold%0d_instr", c), instr, exp_code);
            chk($sformatf("div_hold%0d_ir", c), ir_out, div_word);
            tick();
        end
        chk("div_cnt", {16'd0, ill_cnt}, 32'(exp_cnt));
        chk("div_ill", {31'd0, illegal}, M_ON ? 32'd0 : 32'd1);
        rdy = 1'b1;
        tick();
        chk("div_retire", {31'd0, dv}, 32'd0);

        // two words into a stalled stage fill the skid register
        rdy   = 1'b0;
        ir_dv = 1'b1;
        ir    = 32'h00B50533;
        tick();
        chk("skid_a_rdy", {31'd0, ir_ready}, 32'd1);
        ir = 32'h40B50533;
        tick();
        chk("skid_b_rdy", {31'd0, ir_ready}, 32'd0);
        chk("skid_b_out", ir_out, 32'h00B50533);
        ir = 32'h12345537;
        tick();
        chk("skid_block_out", ir_out, 32'h00B50533);
        chk("skid_block_rdy", {31'd0, ir_ready}, 32'd0);
        ir_dv = 1'b0;
        rdy   = 1'b1;
        tick();
        rdy = 1'b0;
        chk("skid_pop_ir",    ir_out, 32'h40B50533);
        chk("skid_pop_instr", instr, 32'd1);
        chk("skid_pop_dv",    {31'd0, dv}, 32'd1);
        chk("skid_pop_rdy",   {31'd0, ir_ready}, 32'd1);

        // flush with both entries full and an illegal word offered
        ir_dv = 1'b1;
        ir    = 32'h12345537;
        tick();
        chk("flush_pre_rdy", {31'd0, ir_ready}, 32'd0);
        flush = 1'b1;
        ir    = 32'hFFFFFFFF;
        tick();
        chk("flush_dv",  {31'd0, dv}, 32'd0);
        chk("flush_rdy", {31'd0, ir_ready}, 32'd1);
        chk("flush_cnt", {16'd0, ill_cnt}, 32'(exp_cnt));
        // flush with empty buffer and ready: offered word still dropped
        tick();
        flush = 1'b0;
        ir_dv = 1'b0;
        chk("flush2_dv",  {31'd0, dv}, 32'd0);
        chk("flush2_cnt", {16'd0, ill_cnt}, 32'(exp_cnt));
        tick();
        chk("flush_nospur", {31'd0, dv}, 32'd0);

        // counter from zero, then saturation
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        rdy   = 1'b1;
        ir_dv = 1'b1;
        ir    = 32'hFFFFFFFF;
        tick();
        tick();
        tick();
        ir_dv = 1'b0;
        chk("ill3_cnt",   {16'd0, ill_cnt}, 32'd3);
        chk("ill3_instr", instr, 32'd63);
        ir_dv = 1'b1;
        repeat (65531) tick();
        chk("sat_fffe", {16'd0, ill_cnt}, 32'h0000FFFE);
        tick();
        chk("sat_ffff", {16'd0, ill_cnt}, 32'h0000FFFF);
        repeat (3) tick();
        ir_dv = 1'b0;
        chk("sat_hold", {16'd0, ill_cnt}, 32'h0000FFFF);
        tick();

        // asynchronous reset while an entry is held
        rdy   = 1'b0;
        ir_dv = 1'b1;
        ir    = 32'h00B50533;
        tick();
        ir = 32'h40B50533;
        tick();
        chk("hold_dv",  {31'd0, dv}, 32'd1);
        chk("hold_rdy", {31'd0, ir_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        chk("rst_noacc_dv", {31'd0, dv}, 32'd0);
        #2;
        ir_dv = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst_rel_dv",  {31'd0, dv}, 32'd0);
        chk("rst_rel_rdy", {31'd0, ir_ready}, 32'd1);
        rdy = 1'b1;
        tick();
        chk("rst_rel_dv2", {31'd0, dv}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
